// File: rtl/pifo_sram_bank_if.sv
// rtl/pifo_sram_bank_if.sv - read/write request bundle between a PIFO node and its SRAM bank
//
// Signals:
//   i_read, i_read_addr     read request and address (node -> bank)
//   o_read_data, o_rd_valid registered read data and its one-cycle valid (bank -> node)
//   i_write, i_write_addr   write request and address (node -> bank)
//   i_write_data            write data, layout {cnt1,meta1,pay1,cnt0,meta0,pay0}
//   o_ready                 bank finished clearing itself and services requests
// Modports: master = PIFO node side, slave = SRAM bank side.
interface pifo_sram_bank_if #(
    parameter int ADW = 5,
    parameter int DW  = 52
);
    logic           i_read;
    logic [ADW-1:0] i_read_addr;
    logic [DW-1:0]  o_read_data;
    logic           o_rd_valid;
    logic           i_write;
    logic [ADW-1:0] i_write_addr;
    logic [DW-1:0]  i_write_data;
    logic           o_ready;

    modport master (
        output i_read, i_read_addr, i_write, i_write_addr, i_write_data,
        input  o_read_data, o_rd_valid, o_ready
    );

    modport slave (
        input  i_read, i_read_addr, i_write, i_write_addr, i_write_data,
        output o_read_data, o_rd_valid, o_ready
    );
endinterface

// File: rtl/pifo_sram_bank.sv
// rtl/pifo_sram_bank.sv - self-clearing 1R1W storage bank for one PIFO tree level
//
// Ports:
//   i_clk  sole clock, rising edge
//   i_rst  synchronous active-high reset; restarts the clearing sweep
//   bus    pifo_sram_bank_if.slave: read/write requests, registered read data,
//          read valid and ready
// After reset the bank writes EMPTY into every entry (one per cycle) before it
// accepts requests. Reads have one cycle of latency and forward same-cycle
// write data when the addresses match.
module pifo_sram_bank #(
    parameter int PTW      = 16,
    parameter int MTW      = 0,
    parameter int CTW      = 10,
    parameter int SRAM_ADW = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    pifo_sram_bank_if.slave  bus
);
    localparam int DEPTH = 2 ** SRAM_ADW;
    localparam int HW    = CTW + MTW + PTW;
    localparam int DW    = 2 * HW;
    localparam int CNT_W = SRAM_ADW + 1;

    // Empty half: zero counter and metadata, all-ones payload (lowest priority).
    localparam logic [HW-1:0]    EMPTY_HALF = {{(CTW + MTW){1'b0}}, {PTW{1'b1}}};
    localparam logic [DW-1:0]    EMPTY      = {EMPTY_HALF, EMPTY_HALF};
    localparam logic [CNT_W-1:0] LAST_ADDR  = CNT_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [CNT_W-1:0]     init_cnt;
    logic [CNT_W-1:0]     next_cnt;

    logic [DW-1:0]        mem [DEPTH];

    logic                 mem_we;
    logic [SRAM_ADW-1:0]  mem_waddr;
    logic [DW-1:0]        mem_wdata;
    logic                 rd_en;
    logic [DW-1:0]        rd_fwd;

    logic [DW-1:0]        rd_q;
    logic                 rd_valid_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_INIT;
            init_cnt   <= '0;
            rd_q       <= EMPTY;
            rd_valid_q <= 1'b0;
        end else begin
            state      <= next_state;
            init_cnt   <= next_cnt;
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_q <= rd_fwd;
            end
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = init_cnt;
        mem_we     = 1'b0;
        mem_waddr  = bus.i_write_addr;
        mem_wdata  = bus.i_write_data;
        rd_en      = 1'b0;
        case (state)
            ST_INIT: begin
                // Node requests are ignored; the write port belongs to the sweep.
                mem_we    = 1'b1;
                mem_waddr = init_cnt[SRAM_ADW-1:0];
                mem_wdata = EMPTY;
                next_cnt  = init_cnt + 1'b1;
                if (init_cnt == LAST_ADDR) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                mem_we = bus.i_write;
                rd_en  = bus.i_read;
            end
            default: begin
                next_state = ST_INIT;
            end
        endcase
    end

    // Write-first: a read that collides with this cycle's write sees the new data.
    always_comb begin
        rd_fwd = mem[bus.i_read_addr];
        if (bus.i_write && (bus.i_write_addr == bus.i_read_addr)) begin
            rd_fwd = bus.i_write_data;
        end
    end

    // Storage has no reset; contents are defined by the clearing sweep. Nothing
    // is written in a reset cycle so requests present then are dropped.
    always_ff @(posedge i_clk) begin
        if (!i_rst && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.o_read_data = rd_q;
    assign bus.o_rd_valid  = rd_valid_q;
    assign bus.o_ready     = (state == ST_RUN);
endmodule

// File: tb/tb_pifo_sram_bank.sv
// tb/tb_pifo_sram_bank.sv - self-checking bench for pifo_sram_bank
module tb_pifo_sram_bank;
    localparam int PTW   = 16;
    localparam int MTW   = 0;
    localparam int CTW   = 10;
    localparam int ADW   = 5;
    localparam int DW    = 2 * (CTW + MTW + PTW);
    localparam int DEPTH = 2 ** ADW;

    localparam logic [DW-1:0] EMPTY = {10'd0, 16'hFFFF, 10'd0, 16'hFFFF};
    localparam logic [DW-1:0] W7    = {10'd1, 16'h0010, 10'd0, 16'hFFFF};
    localparam logic [DW-1:0] V3    = {10'd2, 16'h0005, 10'd1, 16'h0009};
    localparam logic [DW-1:0] W9    = {10'd5, 16'h1234, 10'd3, 16'h0042};

    logic clk;
    logic rst;

    pifo_sram_bank_if #(.ADW(ADW), .DW(DW)) bus ();

    pifo_sram_bank #(
        .PTW(PTW), .MTW(MTW), .CTW(CTW), .SRAM_ADW(ADW)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Reference model: contents as seen by the node and the expected read port.
    logic [DW-1:0] mem_m [DEPTH];
    logic [DW-1:0] exp_data;
    logic          exp_valid;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = EMPTY;
        exp_data  = EMPTY;
        exp_valid = 1'b0;
    endtask

    task automatic drive(input logic rd, input logic [ADW-1:0] ra,
                         input logic wr, input logic [ADW-1:0] wa,
                         input logic [DW-1:0] wd);
        bus.i_read       = rd;
        bus.i_read_addr  = ra;
        bus.i_write      = wr;
        bus.i_write_addr = wa;
        bus.i_write_data = wd;
    endtask

    // One running-mode cycle: apply request, clock, advance the model.
    task automatic do_cycle(input logic rd, input logic [ADW-1:0] ra,
                            input logic wr, input logic [ADW-1:0] wa,
                            input logic [DW-1:0] wd);
        drive(rd, ra, wr, wa, wd);
        tick();
        if (rd) begin
            exp_data  = (wr && wa == ra) ? wd : mem_m[ra];
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        if (wr) mem_m[wa] = wd;
    endtask

    task automatic idle();
        do_cycle(1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic test_reset();
        int n;
        drive(1'b0, '0, 1'b0, '0, '0);
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if (bus.o_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready got %0b want 0", bus.o_ready);
        end
        vectors++;
        if (bus.o_rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid got %0b want 0", bus.o_rd_valid);
        end
        vectors++;
        if (bus.o_read_data !== EMPTY) begin
            miscompares++;
            $display("FAIL reset_data got %h want %h", bus.o_read_data, EMPTY);
        end
        rst = 1'b0;
        n = 0;
        while (bus.o_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        vectors++;
        if (n != DEPTH) begin
            miscompares++;
            $display("FAIL init_latency got %0d cycles want %0d", n, DEPTH);
        end
        model_clear();
    endtask

    task automatic test_init_readback();
        for (int a = 0; a < DEPTH; a++) begin
            do_cycle(1'b1, ADW'(a), 1'b0, '0, '0);
            vectors++;
            if (bus.o_rd_valid !== 1'b1 || bus.o_read_data !== EMPTY) begin
                miscompares++;
                $display("FAIL init_read addr %0d got %b/%h want 1/%h",
                         a, bus.o_rd_valid, bus.o_read_data, EMPTY);
            end
        end
        idle();
    endtask

    task automatic test_basic_rw();
        do_cycle(1'b0, '0, 1'b1, 5'd7, W7);
        vectors++;
        if (bus.o_rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_wr_valid got %0b want 0", bus.o_rd_valid);
        end
        do_cycle(1'b1, 5'd7, 1'b0, '0, '0);
        vectors++;
        if (bus.o_rd_valid !== 1'b1 || bus.o_read_data !== W7) begin
            miscompares++;
            $display("FAIL basic_read got %b/%h want 1/%h", bus.o_rd_valid, bus.o_read_data, W7);
        end
        idle();
        vectors++;
        if (bus.o_rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_valid_drop got %0b want 0", bus.o_rd_valid);
        end
    endtask

    task automatic test_forwarding();
        do_cycle(1'b1, 5'd3, 1'b1, 5'd3, V3);
        vectors++;
        if (bus.o_rd_valid !== 1'b1 || bus.o_read_data !== V3) begin
            miscompares++;
            $display("FAIL fwd_same got %b/%h want 1/%h", bus.o_rd_valid, bus.o_read_data, V3);
        end
        do_cycle(1'b1, 5'd4, 1'b1, 5'd3, V3);
        vectors++;
        if (bus.o_rd_valid !== 1'b1 || bus.o_read_data !== EMPTY) begin
            miscompares++;
            $display("FAIL fwd_diff got %b/%h want 1/%h", bus.o_rd_valid, bus.o_read_data, EMPTY);
        end
        idle();
    endtask

    task automatic test_hold();
        do_cycle(1'b1, 5'd7, 1'b0, '0, '0);
        vectors++;
        if (bus.o_rd_valid !== 1'b1 || bus.o_read_data !== W7) begin
            miscompares++;
            $display("FAIL hold_read got %b/%h want 1/%h", bus.o_rd_valid, bus.o_read_data, W7);
        end
        for (int i = 0; i < 3; i++) begin
            idle();
            vectors++;
            if (bus.o_rd_valid !== 1'b0 || bus.o_read_data !== W7) begin
                miscompares++;
                $display("FAIL hold_idle%0d got %b/%h want 0/%h",
                         i, bus.o_rd_valid, bus.o_read_data, W7);
            end
        end
    endtask

    task automatic test_random();
        logic            rd;
        logic            wr;
        logic [ADW-1:0]  ra;
        logic [ADW-1:0]  wa;
        logic [DW-1:0]   wd;
        for (int i = 0; i < 300; i++) begin
            rd = ($urandom_range(0, 3) != 0);
            wr = ($urandom_range(0, 1) != 0);
            ra = ADW'($urandom_range(0, 7));
            wa = ADW'($urandom_range(0, 7));
            wd = DW'({$urandom(), $urandom()});
            if ($urandom_range(0, 7) == 0) ra = wa;
            do_cycle(rd, ra, wr, wa, wd);
            vectors++;
            if (bus.o_rd_valid !== exp_valid || bus.o_read_data !== exp_data) begin
                miscompares++;
                $display("FAIL random step %0d got %b/%h want %b/%h",
                         i, bus.o_rd_valid, bus.o_read_data, exp_valid, exp_data);
            end
        end
        idle();
        // Repeated identical writes leave the entry unchanged.
        do_cycle(1'b0, '0, 1'b1, 5'd12, W9);
        do_cycle(1'b0, '0, 1'b1, 5'd12, W9);
        do_cycle(1'b1, 5'd12, 1'b0, '0, '0);
        vectors++;
        if (bus.o_read_data !== W9) begin
            miscompares++;
            $display("FAIL idempotent got %h want %h", bus.o_read_data, W9);
        end
        idle();
    endtask

    task automatic test_init_masking();
        int n;
        drive(1'b0, '0, 1'b0, '0, '0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        while (bus.o_ready !== 1'b1 && n < 100) begin
            if (n == 10) drive(1'b1, '0, 1'b1, '0, DW'(1));
            else         drive(1'b1, ADW'(n), 1'b0, '0, '0);
            tick();
            n++;
            vectors++;
            if (bus.o_rd_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL init_mask_valid cycle %0d got %0b want 0", n, bus.o_rd_valid);
            end
        end
        vectors++;
        if (n != DEPTH) begin
            miscompares++;
            $display("FAIL init_mask_latency got %0d want %0d", n, DEPTH);
        end
        model_clear();
        do_cycle(1'b1, '0, 1'b0, '0, '0);
        vectors++;
        if (bus.o_rd_valid !== 1'b1 || bus.o_read_data !== EMPTY) begin
            miscompares++;
            $display("FAIL init_mask_read got %b/%h want 1/%h", bus.o_rd_valid, bus.o_read_data, EMPTY);
        end
        idle();
    endtask

    task automatic test_midrun_reset();
        int n;
        do_cycle(1'b0, '0, 1'b1, 5'd9, W9);
        do_cycle(1'b1, 5'd9, 1'b0, '0, '0);
        vectors++;
        if (bus.o_read_data !== W9) begin
            miscompares++;
            $display("FAIL midrun_pre got %h want %h", bus.o_read_data, W9);
        end
        // A write presented during the reset cycle must be dropped.
        drive(1'b1, 5'd9, 1'b1, 5'd9, W9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, '0, 1'b0, '0, '0);
        vectors++;
        if (bus.o_ready !== 1'b0 || bus.o_rd_valid !== 1'b0 || bus.o_read_data !== EMPTY) begin
            miscompares++;
            $display("FAIL midrun_rst got %b/%b/%h want 0/0/%h",
                     bus.o_ready, bus.o_rd_valid, bus.o_read_data, EMPTY);
        end
        n = 0;
        while (bus.o_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        vectors++;
        if (n != DEPTH) begin
            miscompares++;
            $display("FAIL midrun_latency got %0d want %0d", n, DEPTH);
        end
        model_clear();
        do_cycle(1'b1, 5'd9, 1'b0, '0, '0);
        vectors++;
        if (bus.o_rd_valid !== 1'b1 || bus.o_read_data !== EMPTY) begin
            miscompares++;
            $display("FAIL midrun_read got %b/%h want 1/%h", bus.o_rd_valid, bus.o_read_data, EMPTY);
        end
        idle();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        drive(1'b0, '0, 1'b0, '0, '0);
        model_clear();
        test_reset();
        test_init_readback();
        test_basic_rw();
        test_forwarding();
        test_hold();
        test_random();
        test_init_masking();
        test_midrun_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pifo_sram_bank.md
PIFO_SRAM_BANK -- requirements
Module: pifo_sram_bank

Interface
REQ-001 SHALL have parameter PTW, default 16, meaning payload width per entry half.
REQ-002 SHALL have parameter MTW, default 0, meaning metadata width per entry half.
REQ-003 SHALL have parameter CTW, default 10, meaning sub-tree counter width per entry half.
REQ-004 SHALL have parameter SRAM_ADW, default 5, meaning address width; DEPTH = 2**SRAM_ADW; DW = 2*(CTW+MTW+PTW).
REQ-005 SHALL have port i_clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port i_read  input  1  read request from PIFO node.
REQ-008 SHALL have port i_read_addr  input  SRAM_ADW  read address.
REQ-009 SHALL have port o_read_data  output  DW  read data, layout {cnt1,meta1,pay1,cnt0,meta0,pay0}.
REQ-010 SHALL have port o_rd_valid  output  1  high one cycle after an accepted read.
REQ-011 SHALL have port i_write  input  1  write request from PIFO node.
REQ-012 SHALL have port i_write_addr  input  SRAM_ADW  write address.
REQ-013 SHALL have port i_write_data  input  DW  write data, same layout as o_read_data.
REQ-014 SHALL have port o_ready  output  1  high when initialisation complete and requests are serviced.

Function
REQ-015 SHALL define EMPTY_HALF = {CTW zeros, MTW zeros, PTW ones}; EMPTY = {EMPTY_HALF, EMPTY_HALF}.
REQ-016 SHALL hold DEPTH x DW storage array, single read port and single write port, both usable same cycle.
REQ-017 SHALL implement FSM states ST_INIT and ST_RUN; reset enters ST_INIT with init counter 0.
REQ-018 In ST_INIT SHALL write EMPTY to address = init counter each cycle, incrementing counter by 1.
REQ-019 SHALL transition ST_INIT -> ST_RUN in the cycle after writing address DEPTH-1; o_ready rises on that transition (DEPTH cycles after reset deasserts).
REQ-020 SHALL remain in ST_RUN until i_rst; no other transition exists.
REQ-021 In ST_INIT SHALL ignore i_read and i_write entirely; o_rd_valid stays 0 and array writes are init-only.
REQ-022 In ST_RUN, i_write SHALL update array[i_write_addr] with i_write_data at the clock edge.
REQ-023 In ST_RUN, i_read SHALL register array[i_read_addr] into o_read_data at the edge; data visible the following cycle (latency 1), o_rd_valid=1 that cycle.
REQ-024 Same-cycle i_read and i_write to the same address SHALL return i_write_data (write-first forwarding).
REQ-025 Same-cycle i_read and i_write to different addresses SHALL return old array contents of the read address.
REQ-026 Without i_read, o_read_data SHALL hold its last value and o_rd_valid SHALL be 0 (node reads data across POP and WB cycles).
REQ-027 Back-to-back reads every cycle SHALL be supported with no bubbles.
REQ-028 Repeated writes with identical data (node writes in both POP and WB) SHALL be idempotent.
REQ-029 Address is full-range; no wrap or bounds logic needed; init counter is SRAM_ADW+1 bits so completion is detected without wrap ambiguity.

Reset
REQ-030 On i_rst=1 at an edge SHALL set: FSM=ST_INIT, init counter=0, o_ready=0, o_rd_valid=0, o_read_data=EMPTY.
REQ-031 Reset asserted mid-RUN or mid-INIT SHALL restart initialisation from address 0; all prior contents lost and re-cleared to EMPTY.
REQ-032 Requests present in the reset cycle SHALL be dropped.

Verification (PTW=16, MTW=0, CTW=10, SRAM_ADW=5: DW=52, DEPTH=32)
REQ-033 Init: release reset, idle -> o_ready=0 for 32 cycles then 1; read addr 0..31 each returns {10'd0,16'hFFFF,10'd0,16'hFFFF}.
REQ-034 Basic R/W: write addr 7 = {10'd1,16'h0010,10'd0,16'hFFFF}, next cycle read 7 -> o_read_data equals written value one cycle later, o_rd_valid=1 exactly one cycle.
REQ-035 Forwarding: same cycle write addr 3 = {10'd2,16'h0005,10'd1,16'h0009} and read addr 3 -> next cycle o_read_data is new value; same with read addr 4 -> EMPTY.
REQ-036 Hold: read addr 7, then 3 idle cycles -> o_read_data stable, o_rd_valid 1 then 0,0,0.
REQ-037 Init masking: assert i_write addr 0 = 52'h1 during cycle 10 of init -> after init, read 0 returns EMPTY.
REQ-038 Mid-run reset: write addr 9 non-EMPTY, pulse i_rst one cycle -> o_ready=0 for 32 cycles, then read 9 returns EMPTY.
